// File: rtl/booth_div_pkg.sv
// Shared definitions for the sequential signed divider: state encoding,
// default width and a two's-complement magnitude helper.
package booth_div_pkg;

    localparam int unsigned DIV_DEFAULT_WIDTH = 8;
    localparam int unsigned DIV_MAX_WIDTH     = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

    // Unsigned magnitude of a sign-extended operand; exact for the most-negative value.
    function automatic logic [DIV_MAX_WIDTH:0] div_mag(input logic [DIV_MAX_WIDTH-1:0] x);
        logic [DIV_MAX_WIDTH-1:0] m;
        m = x[DIV_MAX_WIDTH-1] ? (~x + DIV_MAX_WIDTH'(1)) : x;
        return {1'b0, m};
    endfunction

endpackage

// File: rtl/divider_nr_step.sv
// One combinational non-restoring division iteration on a (WIDTH+2)-bit
// signed partial remainder.
module divider_nr_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH+1:0] pr_i,
    input  logic [WIDTH:0]   dmag_i,
    input  logic             bit_i,
    output logic [WIDTH+1:0] pr_next_c_o,
    output logic             qbit_c_o
);

    logic [WIDTH+1:0] shifted_c;
    logic [WIDTH+1:0] dext_c;

    assign shifted_c = {pr_i[WIDTH:0], bit_i};
    assign dext_c    = {1'b0, dmag_i};

    // Negative remainder adds the divisor back, non-negative subtracts it.
    assign pr_next_c_o = pr_i[WIDTH+1] ? (shifted_c + dext_c) : (shifted_c - dext_c);
    assign qbit_c_o    = ~pr_next_c_o[WIDTH+1];

endmodule

// File: rtl/booth_seq_divider.sv
// Sequential signed divider (truncating, non-restoring) with valid/ready handshakes.
// Define BOOTH_SEQ_DIVIDER_RADIX4_EN to retire two quotient bits per CALC cycle.
module booth_seq_divider
    import booth_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(WIDTH);
`ifdef BOOTH_SEQ_DIVIDER_RADIX4_EN
    localparam logic [CW-1:0] CNT_START = CW'(WIDTH/2 - 1);
`else
    localparam logic [CW-1:0] CNT_START = CW'(WIDTH - 1);
`endif
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH+1:0] pr_q, pr_d;
    logic [WIDTH:0]   dmag_q, dmag_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             neg_q_q, neg_q_d, neg_r_q, neg_r_d;
    logic             dbz_q, dbz_d, ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d, overflow_q, overflow_d;

    logic [WIDTH-1:0] dvd_mag_c, rem_mag_c;
    logic [WIDTH:0]   dsr_mag_c;
    logic [WIDTH+1:0] pr0_c;
    logic             qb0_c;

    assign dvd_mag_c = WIDTH'(div_mag(DIV_MAX_WIDTH'(signed'(dividend))));
    assign dsr_mag_c = (WIDTH+1)'(div_mag(DIV_MAX_WIDTH'(signed'(divisor))));
    assign rem_mag_c = pr_q[WIDTH+1] ? (pr_q[WIDTH-1:0] + dmag_q[WIDTH-1:0]) : pr_q[WIDTH-1:0];

    divider_nr_step #(.WIDTH(WIDTH)) u_step0 (
        .pr_i        (pr_q),
        .dmag_i      (dmag_q),
        .bit_i       (a_q[WIDTH-1]),
        .pr_next_c_o (pr0_c),
        .qbit_c_o    (qb0_c)
    );

`ifdef BOOTH_SEQ_DIVIDER_RADIX4_EN
    logic [WIDTH+1:0] pr1_c;
    logic             qb1_c;

    divider_nr_step #(.WIDTH(WIDTH)) u_step1 (
        .pr_i        (pr0_c),
        .dmag_i      (dmag_q),
        .bit_i       (a_q[WIDTH-2]),
        .pr_next_c_o (pr1_c),
        .qbit_c_o    (qb1_c)
    );
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pr_d          = pr_q;
        dmag_d        = dmag_q;
        a_d           = a_q;
        q_d           = q_q;
        neg_q_d       = neg_q_q;
        neg_r_d       = neg_r_q;
        dbz_d         = dbz_q;
        ovf_d         = ovf_q;
        in_ready_d    = in_ready_q;
        out_valid_d   = out_valid_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        overflow_d    = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    in_ready_d    = 1'b0;
                    div_by_zero_d = 1'b0;
                    overflow_d    = 1'b0;
                    neg_q_d       = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    neg_r_d       = dividend[WIDTH-1];
                    ovf_d         = (dividend == MOST_NEG) && (&divisor);
                    pr_d          = '0;
                    q_d           = '0;
                    dmag_d        = dsr_mag_c;
                    cnt_d         = CNT_START;
                    if (divisor == '0) begin
                        // Raw dividend is kept and returned as the remainder from FIX.
                        dbz_d   = 1'b1;
                        a_d     = dividend;
                        state_d = S_FIX;
                    end else begin
                        dbz_d   = 1'b0;
                        a_d     = dvd_mag_c;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
`ifdef BOOTH_SEQ_DIVIDER_RADIX4_EN
                pr_d = pr1_c;
                q_d  = {q_q[WIDTH-3:0], qb0_c, qb1_c};
                a_d  = {a_q[WIDTH-3:0], 2'b00};
`else
                pr_d = pr0_c;
                q_d  = {q_q[WIDTH-2:0], qb0_c};
                a_d  = {a_q[WIDTH-2:0], 1'b0};
`endif
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                div_by_zero_d = dbz_q;
                overflow_d    = ovf_q;
                if (dbz_q) begin
                    quotient_d  = '1;
                    remainder_d = a_q;
                end else begin
                    quotient_d  = neg_q_q ? -q_q : q_q;
                    remainder_d = neg_r_q ? -rem_mag_c : rem_mag_c;
                end
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            pr_q          <= '0;
            dmag_q        <= '0;
            a_q           <= '0;
            q_q           <= '0;
            neg_q_q       <= 1'b0;
            neg_r_q       <= 1'b0;
            dbz_q         <= 1'b0;
            ovf_q         <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pr_q          <= pr_d;
            dmag_q        <= dmag_d;
            a_q           <= a_d;
            q_q           <= q_d;
            neg_q_q       <= neg_q_d;
            neg_r_q       <= neg_r_d;
            dbz_q         <= dbz_d;
            ovf_q         <= ovf_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            overflow_q    <= overflow_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;
    assign overflow    = overflow_q;

endmodule

// File: doc/booth_seq_divider.md
Name: booth_seq_divider

Overview:
- Sequential signed integer divider. It is the inverse operation of our radix-16 Booth multiplier datapath.
- Used by the FIR filter control path for gain normalisation and coefficient scaling, where a combinational divider is too large.
- Accepts a WIDTH-bit dividend and divisor through a valid/ready handshake.
- Computes quotient and remainder with a multi-cycle non-restoring algorithm and returns them through a second valid/ready handshake.

Parameters:
- WIDTH, 8, operand/result width in bits (two's complement). Must be even and >= 4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  dividend/divisor valid.
- in_ready  output  1  divider can accept an operation.
- dividend  input  WIDTH  signed dividend.
- divisor  input  WIDTH  signed divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  signed quotient.
- remainder  output  WIDTH  signed remainder.
- div_by_zero  output  1  divisor was 0 (valid with out_valid).
- overflow  output  1  most-negative / -1 case (valid with out_valid).

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: state=IDLE; in_ready=1; out_valid=0; quotient=0; remainder=0; div_by_zero=0; overflow=0; all internal registers cleared.
- Reset asserted mid-operation aborts the operation immediately. No result is produced.
- Semantics: truncation toward zero, matching Verilog signed / and %. Remainder takes the sign of the dividend. |remainder| < |divisor|.
- Datapath: magnitudes are formed on acceptance (|x| in WIDTH+1 bits, so the most-negative value is exact). The core runs unsigned non-restoring division on these magnitudes. Signs are reapplied in FIX.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, capture operands.
    - divisor==0 -> DONE with quotient=all ones (-1), remainder=dividend, div_by_zero=1.
    - otherwise -> CALC, with iteration counter = WIDTH-1.
  - CALC: one quotient bit per cycle. Partial remainder is WIDTH+2 bits. Shift left, then add or subtract the divisor magnitude according to the partial-remainder sign. Counter decrements; at counter 0 -> FIX.
  - FIX: final remainder correction (add divisor magnitude if negative). Negate quotient if operand signs differ. Negate remainder if dividend is negative. -> DONE.
  - DONE: out_valid=1; outputs held stable. On out_ready -> IDLE (out_valid drops the next cycle).
- Overflow: dividend = -2^(WIDTH-1) and divisor = -1 gives quotient = -2^(WIDTH-1) (wrapped), remainder=0, overflow=1. It is computed through the normal CALC path.
- Latency:
  - Normal operation: out_valid is high WIDTH+1 cycles after the accepting edge (WIDTH=8: 9 cycles).
  - Divide by zero: out_valid is high 1 cycle after the accepting edge.
- in_ready=0 in CALC, FIX and DONE. in_valid is ignored there. Operands are not re-sampled.
- out_ready while not in DONE has no effect. Backpressure in DONE is unbounded; outputs do not change.
- div_by_zero and overflow are cleared on the next accepted operation.

Optional Feature:
- Macro: BOOTH_SEQ_DIVIDER_RADIX4_EN.
- Defined: CALC retires two quotient bits per cycle. This uses two chained non-restoring steps. The counter starts at WIDTH/2-1. Normal latency becomes WIDTH/2+1 cycles (WIDTH=8: 5). Divide-by-zero latency is unchanged.
- Undefined: one bit per cycle as specified above. Results are bit-identical in both builds.

Decomposition:
- Shared package booth_div_pkg:
  - state encoding constants S_IDLE, S_CALC, S_FIX, S_DONE.
  - function for two's-complement magnitude.
  - DIV_DEFAULT_WIDTH constant.
- One sub-module, divider_nr_step: a combinational single non-restoring iteration.
  - Inputs: partial remainder, divisor magnitude, next dividend bit.
  - Outputs: new partial remainder, quotient bit.
  - Instanced once, or twice under BOOTH_SEQ_DIVIDER_RADIX4_EN.

Test Plan:
- 100 / 7 -> out_valid after 9 cycles; quotient=14, remainder=2, flags 0.
- -100 / 7 -> quotient=-14, remainder=-2.
- 100 / -7 -> quotient=-14, remainder=2.
- -128 / -1 -> quotient=-128, remainder=0, overflow=1.
- 5 / 0 -> out_valid 1 cycle after accept; quotient=-1, remainder=5, div_by_zero=1.
- Hold out_ready=0 for 20 cycles in DONE:
  - outputs stable; in_ready=0.
  - second in_valid pulse is ignored.
- Separately, pulse rst_n low at CALC cycle 4 -> outputs return to reset values and in_ready=1.
- Randomised sweep of all 65536 operand pairs is compared against Verilog signed / and %, in both macro builds.
